// File: rtl/piso_pkg.sv
// piso_pkg: types and helpers for the parallel-in serial-out transmitter.
// The counter-width helper is also used by receiver-side bench code.
package piso_pkg;

    // Two-state transmit FSM.
    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_e;

    // Bit-counter width for a word of the given width. The result is never
    // below 1, so a 2-bit word still gets a 1-bit counter.
    function automatic int piso_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a valid/ready load port.
// A word accepted on an edge has its first bit on so right after that edge.
// A new word can be accepted during the last-bit cycle of the current word,
// so consecutive words stream out with no idle gap.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = piso_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    // Bit that goes on the line for a given shift-register image.
    function automatic logic head_bit(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? s[WIDTH-1] : s[0];
    endfunction

    // Shift register after one bit has been sent, zero filled.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
    endfunction

    // Registered state.
    piso_state_e      r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_so;
    logic             r_so_valid;
    logic             r_busy;
    logic             r_done;

    // Next-state values.
    piso_state_e      w_state_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic [WIDTH-1:0] w_shreg_nx;
    logic             w_so_nx;
    logic             w_live_nx;
    logic             w_done_nx;

    logic             w_last;
    logic             w_ready;
    logic             w_accept;

    // The last-bit cycle doubles as the load window for the next word.
    assign w_last   = (r_state == PISO_SHIFT) && (r_cnt == LAST);
    assign w_ready  = !rst && ((r_state == PISO_IDLE) || w_last);
    assign w_accept = load_valid && w_ready;

    // Next state, counter and shift register; outputs are derived from the
    // next state so that the registered outputs line up with the bit on so.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shreg_nx = r_shreg;
        unique case (r_state)
            PISO_IDLE: begin
                if (w_accept) begin
                    w_state_nx = PISO_SHIFT;
                    w_cnt_nx   = '0;
                    w_shreg_nx = pi;
                end
            end
            PISO_SHIFT: begin
                if (w_last) begin
                    if (w_accept) begin
                        w_state_nx = PISO_SHIFT;
                        w_cnt_nx   = '0;
                        w_shreg_nx = pi;
                    end else begin
                        w_state_nx = PISO_IDLE;
                        w_cnt_nx   = '0;
                        w_shreg_nx = '0;
                    end
                end else begin
                    w_cnt_nx   = r_cnt + CW'(1);
                    w_shreg_nx = shift_once(r_shreg);
                end
            end
            default: begin
                w_state_nx = PISO_IDLE;
                w_cnt_nx   = '0;
                w_shreg_nx = '0;
            end
        endcase

        w_live_nx = (w_state_nx == PISO_SHIFT);
        w_so_nx   = w_live_nx && head_bit(w_shreg_nx);
        w_done_nx = w_live_nx && (w_cnt_nx == LAST);
    end

    // State and output registers; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PISO_IDLE;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_so       <= 1'b0;
            r_so_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_shreg    <= w_shreg_nx;
            r_so       <= w_so_nx;
            r_so_valid <= w_live_nx;
            r_busy     <= w_live_nx;
            r_done     <= w_done_nx;
        end
    end

    assign load_ready = w_ready;
    assign so         = r_so;
    assign so_valid   = r_so_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed vector table for two piso_tx instances (MSB-first and
// LSB-first) sharing one stimulus, then a random loopback stream checked
// against a behavioural deserialiser.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pi = 4'b0;
    logic       load_valid = 1'b0;

    logic rdy_m, so_m, sov_m, busy_m, done_m;
    logic rdy_l, so_l, sov_l, busy_l, done_l;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .pi(pi), .load_valid(load_valid),
        .load_ready(rdy_m), .so(so_m), .so_valid(sov_m), .busy(busy_m), .done(done_m)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .pi(pi), .load_valid(load_valid),
        .load_ready(rdy_l), .so(so_l), .so_valid(sov_l), .busy(busy_l), .done(done_l)
    );

    typedef struct {
        logic       rst;
        logic       lv;
        logic [3:0] pi;
        logic       rdy;   // load_ready during the cycle, before the edge
        logic       so;    // MSB-first so after the edge
        logic       sol;   // LSB-first so after the edge
        logic       sov;   // so_valid and busy after the edge
        logic       done;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic lv, input logic [3:0] p,
                       input logic rd, input logic s, input logic sl,
                       input logic v, input logic d);
        vec_t t;
        t.rst = r; t.lv = lv; t.pi = p; t.rdy = rd;
        t.so = s; t.sol = sl; t.sov = v; t.done = d;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    logic [3:0] words[$];
    logic [3:0] cur;
    logic [3:0] rxm, rxl;
    int         nm, nl, sent, got_m, got_l;
    logic       acc;

    initial begin
        //   rst lv  pi       rdy so sol v  done
        // reset, then one idle cycle
        add(1, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 1, 0, 0, 0, 0);
        // single word 1011: MSB 1,0,1,1  LSB 1,1,0,1
        add(0, 1, 4'b1011, 1, 1, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 0, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 0, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 1, 1, 1);
        add(0, 0, 4'b0000, 1, 0, 0, 0, 0);
        // pi wiggling while idle has no effect
        add(0, 0, 4'b1111, 1, 0, 0, 0, 0);
        // back-to-back 1011 then 0110, load_valid held high
        add(0, 1, 4'b1011, 1, 1, 1, 1, 0);
        add(0, 1, 4'b0110, 0, 0, 1, 1, 0);
        add(0, 1, 4'b0110, 0, 1, 0, 1, 0);
        add(0, 1, 4'b0110, 0, 1, 1, 1, 1);
        add(0, 1, 4'b0110, 1, 0, 0, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 0, 0, 1, 1);
        add(0, 0, 4'b0000, 1, 0, 0, 0, 0);
        // hold-off: 0001, then 1111 offered from the 2nd bit cycle
        add(0, 1, 4'b0001, 1, 0, 1, 1, 0);
        add(0, 1, 4'b1111, 0, 0, 0, 1, 0);
        add(0, 1, 4'b1111, 0, 0, 0, 1, 0);
        add(0, 1, 4'b1111, 0, 1, 0, 1, 1);
        add(0, 1, 4'b1111, 1, 1, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 1, 1, 1);
        add(0, 0, 4'b0000, 1, 0, 0, 0, 0);
        // reset mid-word 1010 (with load_valid also high), then 0101
        add(0, 1, 4'b1010, 1, 1, 0, 1, 0);
        add(0, 0, 4'b0000, 0, 0, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 0, 1, 0);
        add(1, 1, 4'b1111, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0101, 1, 0, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 0, 1, 0);
        add(0, 0, 4'b0000, 0, 0, 1, 1, 0);
        add(0, 0, 4'b0000, 0, 1, 0, 1, 1);
        add(0, 0, 4'b0000, 1, 0, 0, 0, 0);

        @(posedge clk); #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; load_valid = vq[i].lv; pi = vq[i].pi;
            #1;
            chk("ready_m", i, rdy_m, vq[i].rdy);
            chk("ready_l", i, rdy_l, vq[i].rdy);
            @(posedge clk); #1;
            chk("so_m",    i, so_m,   vq[i].so);
            chk("so_l",    i, so_l,   vq[i].sol);
            chk("valid_m", i, sov_m,  vq[i].sov);
            chk("valid_l", i, sov_l,  vq[i].sov);
            chk("busy_m",  i, busy_m, vq[i].sov);
            chk("busy_l",  i, busy_l, vq[i].sov);
            chk("done_m",  i, done_m, vq[i].done);
            chk("done_l",  i, done_l, vq[i].done);
        end

        // loopback: 20 random words streamed into a behavioural deserialiser
        rst = 1'b0; sent = 0; got_m = 0; got_l = 0; nm = 0; nl = 0;
        rxm = '0; rxl = '0;
        cur = 4'($urandom_range(0, 15));
        for (int c = 0; c < 300 && (got_m < 20 || got_l < 20); c++) begin
            load_valid = (sent < 20);
            pi = load_valid ? cur : 4'($urandom_range(0, 15));
            #1;
            acc = load_valid && rdy_m;
            @(posedge clk); #1;
            if (acc) begin
                words.push_back(cur);
                sent++;
                cur = 4'($urandom_range(0, 15));
            end
            if (sov_m) begin
                rxm = {rxm[2:0], so_m};
                nm++;
                chk("lb_done_m", got_m, done_m, (nm == 4));
                if (nm == 4) begin
                    chk("lb_word_m", got_m, rxm, words[got_m]);
                    got_m++;
                    nm = 0;
                end
            end
            if (sov_l) begin
                rxl = {so_l, rxl[3:1]};
                nl++;
                chk("lb_done_l", got_l, done_l, (nl == 4));
                if (nl == 4) begin
                    chk("lb_word_l", got_l, rxl, words[got_l]);
                    got_l++;
                    nl = 0;
                end
            end
        end
        chk("lb_count_m", 0, got_m, 20);
        chk("lb_count_l", 0, got_l, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
